// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath: coin denominations, their
// unit values, the coin_in emitter states and the pending-unit width.
package vending_pkg;

  localparam int UNIT_W = 3;

  typedef enum logic [1:0] {
    COIN_1   = 2'b00,
    COIN_2   = 2'b01,
    COIN_5   = 2'b10,
    COIN_BAD = 2'b11
  } coin_type_e;

  typedef enum logic [1:0] {
    EMIT_IDLE  = 2'd0,
    EMIT_PULSE = 2'd1,
    EMIT_GAP   = 2'd2
  } emit_state_e;

  localparam logic [UNIT_W-1:0] UNITS_1 = 3'd1;
  localparam logic [UNIT_W-1:0] UNITS_2 = 3'd2;
  localparam logic [UNIT_W-1:0] UNITS_5 = 3'd5;

  // Invalid codes are worth nothing; callers reject them separately.
  function automatic logic [UNIT_W-1:0] coin_units(input logic [1:0] code);
    logic [UNIT_W-1:0] u;
    case (code)
      COIN_1:  u = UNITS_1;
      COIN_2:  u = UNITS_2;
      COIN_5:  u = UNITS_5;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/coin_debouncer.sv
// Synchronizes the raw coin sensor, filters bounce shorter than
// DEBOUNCE_CYCLES and flags each debounced rising edge for one cycle.
module coin_debouncer
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sense_raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  // The counter only runs while the synchronized level disagrees with db;
  // any return to agreement restarts the qualification window.
  always_comb begin
    s1_d   = sense_raw;
    s2_d   = s1_q;
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = ~db_q;
        rise_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: values debounced coin events, queues credited units and
// replays them as single-cycle coin_in pulses separated by PULSE_GAP cycles.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_GAP       = 2,
  parameter int MAX_PENDING     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_sense,
  input  logic [1:0]        coin_type,
  input  logic              accept_en,
  output logic              coin_in,
  output logic              coin_reject,
  output logic              busy,
  output logic [UNIT_W-1:0] pending
);

  localparam int GW = $clog2(PULSE_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(PULSE_GAP - 1);

  logic              db_rise;
  logic [1:0]        t1_q, t1_d;
  logic [1:0]        t2_q, t2_d;
  logic [UNIT_W-1:0] pending_q, pending_d;
  logic              coin_in_q, coin_in_d;
  logic              coin_reject_q, coin_reject_d;
  logic              busy_q, busy_d;
  emit_state_e       state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [UNIT_W-1:0] units;
  logic [UNIT_W:0]   sum;
  logic              take;
  logic              dec;

  coin_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .sense_raw(coin_sense),
    .rise     (db_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_q          <= '0;
      t2_q          <= '0;
      pending_q     <= '0;
      coin_in_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      state_q       <= EMIT_IDLE;
      gap_q         <= '0;
    end else begin
      t1_q          <= t1_d;
      t2_q          <= t2_d;
      pending_q     <= pending_d;
      coin_in_q     <= coin_in_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
      state_q       <= state_d;
      gap_q         <= gap_d;
    end
  end

  // Valuation: a coin is taken only if the consumer is willing, the code is
  // valid and the queue has room for all of its units at once.
  always_comb begin
    t1_d          = coin_type;
    t2_d          = t1_q;
    units         = coin_units(t2_q);
    sum           = {1'b0, pending_q} + {1'b0, units};
    take          = 1'b0;
    coin_reject_d = 1'b0;
    if (db_rise) begin
      if (!accept_en || (t2_q == COIN_BAD) || (sum > (UNIT_W+1)'(MAX_PENDING))) begin
        coin_reject_d = 1'b1;
      end else begin
        take = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    coin_in_d = 1'b0;
    dec       = 1'b0;
    case (state_q)
      EMIT_IDLE: begin
        if (pending_q != '0) state_d = EMIT_PULSE;
      end
      EMIT_PULSE: begin
        coin_in_d = 1'b1;
        dec       = 1'b1;
        gap_d     = '0;
        state_d   = EMIT_GAP;
      end
      EMIT_GAP: begin
        if (gap_q == GAP_LAST) state_d = EMIT_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = EMIT_IDLE;
    endcase
  end

  // Credit and emission may land on the same edge; both apply together.
  always_comb begin
    pending_d = pending_q;
    if (take) pending_d = pending_d + units;
    if (dec)  pending_d = pending_d - UNIT_W'(1);
    busy_d = (pending_d != '0) || (state_d != EMIT_IDLE);
  end

  assign coin_in     = coin_in_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign pending     = pending_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the vending datapath: turns the raw mechanical coin sensor and denomination lines into clean single-cycle unit pulses on coin_in, which feed the vending-machine FSM's coin counter directly. Synchronizes and debounces the sensor, validates and values each coin, and rejects coins the machine cannot take. Queued units are then emitted as a spaced pulse train, so the consumer counts exactly one unit per pulse.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a sensor level change; ≥1
- PULSE_GAP, 2, low cycles forced between consecutive coin_in pulses; ≥1
- MAX_PENDING, 7, ceiling on queued units; ≤7
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high; clock clk
- coin_sense  in  1  raw coin-present sensor, asynchronous to clk, bouncy
- coin_type  in  2  denomination code, asynchronous, stable while coin_sense high: 00=1 unit, 01=2 units, 10=5 units, 11=invalid
- accept_en  in  1  consumer willing to take new coins (synchronous)
- coin_in  out  1  one-cycle pulse per unit credited
- coin_reject  out  1  one-cycle pulse when a detected coin is refused
- busy  out  1  high while units are pending or the emitter is not IDLE
- pending  out  3  units queued and not yet emitted

## Operation
- Reset: all outputs 0, pending=0, emitter IDLE, synchronizers 0, debounced level db=0, debounce counter 0.
- Input conditioning: coin_sense and coin_type each pass through a 2-flop synchronizer (s2, t2).
- Debounce: the counter clears whenever s2==db and increments while s2!=db. db toggles on the edge where the count reaches DEBOUNCE_CYCLES, and the counter clears on that edge. Glitches shorter than DEBOUNCE_CYCLES never change db.
- Only a rising db edge is a coin event; falling edges are ignored apart from debouncing.
- Coin event, decided on the edge after db rises, using t2 and accept_en as sampled in the db-rise cycle:
  - Reject (coin_reject=1 for one cycle, no credit) if accept_en=0, if type 11, or if pending+units > MAX_PENDING.
  - Otherwise pending += units (1, 2 or 5).
- Emitter FSM:
  - IDLE → PULSE when pending≠0.
  - PULSE: coin_in=1 for exactly one cycle and pending decrements, then → GAP.
  - GAP: hold for PULSE_GAP cycles, then → IDLE. If pending≠0 at that point, IDLE → PULSE on the next edge.
- Simultaneous accept and decrement in the same cycle: pending <= pending + units − 1. No unit is lost or double-counted.
- accept_en only gates new coins. Units already pending are always emitted.
- Reset mid-train drops all pending units; no further coin_in pulses are produced.
- If coin_sense is held high through reset release, it is counted as a coin after debounce, because db resets to 0.

## Timing
- Raw rise set up before edge 0 gives: s2 high at edge 1, db high at edge 1+DEBOUNCE_CYCLES, pending/coin_reject updated at edge 2+DEBOUNCE_CYCLES, first coin_in high after edge 4+DEBOUNCE_CYCLES.
- Pulse period is PULSE_GAP+2 cycles (PULSE, PULSE_GAP×GAP, IDLE).
- coin_in, coin_reject, busy and pending are all registered outputs, with no combinational path from inputs.
- Minimum coin spacing is 2×DEBOUNCE_CYCLES+4 cycles (rise, then fall, then rise). Faster toggling is filtered, not queued.

## Structure
- Shared vending_pkg holds:
  - coin_type codes and their unit values (1/2/5)
  - emitter state enum (IDLE/PULSE/GAP)
  - unit width constant (3)
- Natural sub-module: coin_debouncer, containing the 2-flop synchronizer, counter and db, with a one-cycle rise output. It is parameterized by DEBOUNCE_CYCLES, with counter width $clog2(DEBOUNCE_CYCLES+1).
- The top level holds valuation, the pending counter and the emitter FSM.

## Test plan
- DEBOUNCE_CYCLES=4, PULSE_GAP=2. A clean type-00 coin with accept_en=1 → exactly 1 coin_in pulse; first coin_in high 8 cycles after the raw rise (edge 4+DEBOUNCE_CYCLES); busy falls after the last GAP.
- Type-10 coin → pending=5 on the accept edge, then 5 coin_in pulses exactly 4 cycles apart; pending counts 5→0.
- Bounce of 3-cycle pulses on coin_sense, then a stable high → a single coin event; a lone 3-cycle glitch → no pulse, no reject.
- Type 11, or any coin with accept_en=0 → one coin_reject pulse, pending unchanged, no coin_in.
- pending=4, then a type-10 coin arrives → reject (9>7). pending=3 with a type-01 coin accepted in a PULSE cycle → pending=4 next (3+2−1).
- rst asserted mid-train with pending=3 → all outputs 0 immediately; no further pulses after release with coin_sense low.
